// File: rtl/keyboard_pio_edge.sv
// keyboard_pio_edge: WIDTH-bit Avalon-MM input port with input synchroniser,
// per-bit edge capture, interrupt mask and level-sensitive irq.
module keyboard_pio_edge #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0,
    parameter int IRQ_EN      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int PRIME = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] sync_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] edge_capture;
    logic [2:0]       prime_cnt;
    logic             primed;
    logic             wr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign sync         = chain[SYNC_STAGES-1];
    assign wr           = chipselect & ~write_n;
    assign primed       = (prime_cnt == 3'(PRIME));
    assign unused_wdata = ^writedata;

    // input synchroniser chain plus delayed copy for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain  <= '0;
            sync_d <= '0;
        end else begin
            chain  <= {chain[SYNC_STAGES-2:0], in_port};
            sync_d <= sync;
        end
    end

    // count until the reset-zeroed chain has filled with real samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 3'd1;
        end
    end

    // per-bit edge events, suppressed until the chain is primed
    always_comb begin
        rise = sync & ~sync_d;
        fall = ~sync & sync_d;
        ev   = '0;
        if (primed) begin
            case (EDGE_TYPE)
                0:       ev = rise;
                1:       ev = fall;
                default: ev = rise | fall;
            endcase
        end
    end

    // write-one-to-clear strobe for the capture register
    always_comb begin
        clr = '0;
        if (wr && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
    end

    // mask register and edge capture; a new edge beats a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask         <= '0;
            edge_capture <= '0;
        end else begin
            if (IRQ_EN != 0 && wr && address == 2'd2) begin
                mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= ev | (edge_capture & ~clr);
        end
    end

    // read mux, zero-extended above WIDTH
    always_comb begin
        rd_mux = '0;
        unique case (address)
            2'd0: rd_mux[WIDTH-1:0] = sync;
            2'd1: rd_mux = '0;
            2'd2: rd_mux[WIDTH-1:0] = mask;
            2'd3: rd_mux[WIDTH-1:0] = edge_capture;
        endcase
    end

    // readdata registered every cycle, no wait states
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = (IRQ_EN != 0) ? |(edge_capture & mask) : 1'b0;

endmodule
